// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the serial arithmetic blocks: FSM state encoding
// and the bit-counter width helper.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Counter must index bits 0..width-1.
  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for the serial subtractor with a start/ready request
// and a one-cycle done pulse.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Bin;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] Diff;
  logic             Bout;
  logic             Ovf;

  modport master (
    output start, A, B, Bin,
    input  ready, done, Diff, Bout, Ovf
  );

  modport slave (
    input  start, A, B, Bin,
    output ready, done, Diff, Bout, Ovf
  );
endinterface

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: Diff = A - B - Bin, Bout set when the bit
// needs to borrow.
module full_subtractor (
  input  logic A,
  input  logic B,
  input  logic Bin,
  output logic Diff,
  output logic Bout
);

  assign Diff = A ^ B ^ Bin;
  assign Bout = (~A & B) | (~(A ^ B) & Bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial A - B - Bin, LSB first, one bit per clock through a single
// full-subtractor cell with the borrow carried in a register.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_subtractor_if.slave   bus
);

  localparam int             CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             brw_q, brw_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;
  logic             cell_diff, cell_bout;

  full_subtractor u_cell (
    .A    (a_sh_q[0]),
    .B    (b_sh_q[0]),
    .Bin  (brw_q),
    .Diff (cell_diff),
    .Bout (cell_bout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      brw_q   <= 1'b0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      diff_q  <= diff_d;
      cnt_q   <= cnt_d;
      brw_q   <= brw_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    diff_d  = diff_q;
    cnt_d   = cnt_q;
    brw_d   = brw_q;
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          a_sh_d  = bus.A;
          b_sh_d  = bus.B;
          brw_d   = bus.Bin;
          a_msb_d = bus.A[WIDTH-1];
          b_msb_d = bus.B[WIDTH-1];
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        res_d  = {cell_diff, res_q[WIDTH-1:1]};
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        brw_d  = cell_bout;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          // The bit processed now is the result MSB, so overflow is decided here.
          diff_d  = {cell_diff, res_q[WIDTH-1:1]};
          bout_d  = cell_bout;
          ovf_d   = (a_msb_q != b_msb_q) & (cell_diff != a_msb_q);
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.ready = (state_q == ST_IDLE);
  assign bus.done  = (state_q == ST_DONE);
  assign bus.Diff  = diff_q;
  assign bus.Bout  = bout_q;
  assign bus.Ovf   = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed checks of the 8-bit serial subtractor: reset, timing, borrow and
// overflow corners, ignored start during RUN, and abort by reset.
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  serial_subtractor_if #(.WIDTH(8)) bus ();

  serial_subtractor #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_ready"}, bus.ready, 1);
    chk({tag, "_done"},  bus.done,  0);
    chk({tag, "_diff"},  bus.Diff,  0);
    chk({tag, "_bout"},  bus.Bout,  0);
    chk({tag, "_ovf"},   bus.Ovf,   0);
  endtask

  // Called #1 after an edge with the FSM idle; start is sampled on the next edge.
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic bin, input logic [7:0] ed, input logic eb,
                        input logic eo);
    chk({tag, "_ready_pre"}, bus.ready, 1);
    bus.start = 1'b1; bus.A = a; bus.B = b; bus.Bin = bin;
    tick();
    bus.start = 1'b0; bus.A = ~a; bus.B = ~b; bus.Bin = ~bin;
    chk({tag, "_ready_t0"}, bus.ready, 0);
    chk({tag, "_done_t0"},  bus.done,  0);
    for (int i = 1; i < 8; i++) begin
      tick();
      chk($sformatf("%s_ready_t%0d", tag, i), bus.ready, 0);
      chk($sformatf("%s_done_t%0d", tag, i),  bus.done,  0);
    end
    tick();
    chk({tag, "_done"},  bus.done,  1);
    chk({tag, "_ready"}, bus.ready, 0);
    chk({tag, "_diff"},  bus.Diff,  ed);
    chk({tag, "_bout"},  bus.Bout,  eb);
    chk({tag, "_ovf"},   bus.Ovf,   eo);
    $display("op %s: A=%h B=%h Bin=%0d -> Diff=%h Bout=%0d Ovf=%0d", tag, a, b, bin,
             bus.Diff, bus.Bout, bus.Ovf);
    tick();
    chk({tag, "_done_after"},  bus.done,  0);
    chk({tag, "_ready_after"}, bus.ready, 1);
    chk({tag, "_diff_hold"},   bus.Diff,  ed);
  endtask

  initial begin
    bus.start = 1'b0; bus.A = '0; bus.B = '0; bus.Bin = 1'b0;

    // Reset held for three edges.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_idle_zero($sformatf("reset%0d", i));
    end
    rst = 1'b0;
    tick();
    chk_idle_zero("idle");

    run_op("5a_3c",   8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0);
    run_op("00_01",   8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
    run_op("10_0f_b", 8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0);
    run_op("80_01",   8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
    run_op("7f_ff",   8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);

    // start during RUN is ignored; start held through DONE begins a new op in IDLE.
    bus.start = 1'b1; bus.A = 8'h5A; bus.B = 8'h3C; bus.Bin = 1'b0;
    tick();                                  // edge t
    bus.A = 8'hFF; bus.B = 8'h00;            // start stays high
    for (int i = 1; i < 9; i++) tick();      // edge t+8 -> DONE
    chk("hold_done",  bus.done, 1);
    chk("hold_diff",  bus.Diff, 8'h1E);
    chk("hold_bout",  bus.Bout, 0);
    tick();                                  // t+9 -> IDLE
    chk("hold_ready", bus.ready, 1);
    tick();                                  // t+10 samples FF-00
    bus.start = 1'b0;
    chk("hold_run",   bus.ready, 0);
    for (int i = 1; i < 9; i++) tick();
    chk("hold2_done", bus.done, 1);
    chk("hold2_diff", bus.Diff, 8'hFF);
    chk("hold2_bout", bus.Bout, 0);
    chk("hold2_ovf",  bus.Ovf,  0);
    $display("op held_start: A=ff B=00 Bin=0 -> Diff=%h Bout=%0d Ovf=%0d",
             bus.Diff, bus.Bout, bus.Ovf);
    tick();

    // Reset at cnt=4 aborts: outputs cleared, no done pulse.
    bus.start = 1'b1; bus.A = 8'h80; bus.B = 8'h01; bus.Bin = 1'b0;
    tick();                                  // edge t, cnt=0
    bus.start = 1'b0;
    for (int i = 1; i < 5; i++) tick();      // cnt=4
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_idle_zero("abort");
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("abort_nodone%0d", i), bus.done, 0);
    end
    $display("op abort: reset mid-run, ready=%0d Diff=%h", bus.ready, bus.Diff);

    run_op("after_abort", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
